fft_stage_sequencer: RTL and testbench



---
 rtl/fft_stage_sequencer.sv | 68 ++++++
 tb/tb_fft_stage_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: stage/butterfly sequencer for a radix-2 FFT with drain gaps and a start/ready/done handshake.
// Optional FFT_STAGE_DONE_EN adds a stage_done pulse on the last drain cycle of each stage.
module fft_stage_sequencer #(
  parameter int NUMSTAGES    = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           stage_num,
  output logic [NUMSTAGES-3:0] counter,
  output logic                 bf_valid
`ifdef FFT_STAGE_DONE_EN
  ,
  output logic                 stage_done
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
  state_t state, nxt;
  logic [3:0] dcnt;
  logic [2:0] stg;
  logic last_dr, last_stg;
  assign last_dr  = dcnt == 4'(DRAIN_CYCLES - 1);
  assign last_stg = stg == 3'(NUMSTAGES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // hold is ignored in IDLE and FIN so a start is never lost and completion always finishes
  always_comb
    nxt = abort ? S_IDLE :
          state == S_IDLE ? (start ? S_RUN : S_IDLE) :
          state == S_FIN ? S_IDLE :
          hold ? state :
          state == S_RUN ? (&counter ? S_DRAIN : S_RUN) :
          !last_dr ? S_DRAIN :
          last_stg ? S_FIN : S_RUN;
  always_comb begin
    ready     = state == S_IDLE;
    busy      = state == S_RUN || state == S_DRAIN;
    done      = state == S_FIN;
    stage_num = busy ? stg : 3'b111;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      counter  <= '0;
      stg      <= '0;
      dcnt     <= '0;
      bf_valid <= 1'b0;
    end else begin
      bf_valid <= nxt == S_RUN && (state == S_IDLE || !hold);
      counter  <= state == S_RUN && nxt == S_RUN ? counter + (NUMSTAGES-2)'(!hold) : '0;
      dcnt     <= state == S_DRAIN && nxt == S_DRAIN ? dcnt + 4'(!hold) : '0;
      stg      <= nxt == S_IDLE || nxt == S_FIN ? '0 :
                  state == S_DRAIN && nxt == S_RUN ? stg + 3'd1 : stg;
    end
`ifdef FFT_STAGE_DONE_EN
  // raised on the edge entering the final drain cycle; a held final cycle does not repeat it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stage_done <= 1'b0;
    else stage_done <= nxt == S_DRAIN && !hold &&
                       (state == S_RUN ? DRAIN_CYCLES == 1 : dcnt == 4'(DRAIN_CYCLES - 2));
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed and random checks of fft_stage_sequencer against a position-based run model.
module tb_fft_stage_sequencer;
  localparam int NS = 5, D = 2, B = 1 << (NS - 2), L = B + D;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, hold = 0;
  logic ready, busy, done, bf_valid;
  logic [2:0] stage_num;
  logic [NS-3:0] counter;
  int passed = 0, total = 0;
  bit active, indone, held;
  int pos, n, sd_cnt;
`ifdef FFT_STAGE_DONE_EN
  logic stage_done;
`endif
  fft_stage_sequencer #(.NUMSTAGES(NS), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .ready(ready), .busy(busy), .done(done), .stage_num(stage_num),
    .counter(counter), .bf_valid(bf_valid)
`ifdef FFT_STAGE_DONE_EN
    , .stage_done(stage_done)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    active = 0; indone = 0; held = 0; pos = 0;
  endtask
  task automatic check_all();
    bit in_bf;
    in_bf = active && (pos % L) < B;
    chk("ready", 32'(ready), 32'(!active && !indone));
    chk("busy", 32'(busy), 32'(active));
    chk("done", 32'(done), 32'(indone));
    chk("stage_num", 32'(stage_num), active ? 32'(pos / L) : 32'd7);
    chk("counter", 32'(counter), in_bf ? 32'(pos % L) : 32'd0);
    chk("bf_valid", 32'(bf_valid), 32'(in_bf && !held));
`ifdef FFT_STAGE_DONE_EN
    chk("stage_done", 32'(stage_done), 32'(active && (pos % L) == L - 1 && !held));
    if (stage_done) sd_cnt++;
`endif
  endtask
  task automatic step(input bit s, input bit a, input bit h);
    start = s; abort = a; hold = h;
    @(posedge clk);
    if (a) model_reset();
    else if (indone) indone = 0;
    else if (!active) begin
      if (s) begin active = 1; pos = 0; held = 0; end
    end else if (h) held = 1;
    else begin
      held = 0; pos++;
      if (pos == NS * L) begin active = 0; indone = 1; end
    end
    #1 check_all();
  endtask
  task automatic run_to(input int target);
    int k;
    k = 0;
    while (!(active && pos == target) && k < 500) begin step(0, 0, 0); k++; end
    chk("reach_pos", 32'(active && pos == target), 32'd1);
  endtask
  task automatic finish_run(output int cnt, input int already);
    cnt = already;
    while (!done && cnt < 300) begin step(0, 0, 0); cnt++; end
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    rst_n = 1;
    step(0, 0, 0);
    // full run: count from the cycle start is presented to the done cycle
    sd_cnt = 0;
    step(1, 0, 0);
    finish_run(n, 1);
    chk("latency", 32'(n), 32'(NS * L + 1));
`ifdef FFT_STAGE_DONE_EN
    chk("stage_done_count", 32'(sd_cnt), 32'(NS));
`endif
    step(0, 0, 0);
    chk("ready_after", 32'(ready), 32'd1);
    // hold three cycles at stage 2, counter 5
    step(1, 0, 0);
    n = 1;
    while (!(active && pos == 2 * L + 5) && n < 200) begin step(0, 0, 0); n++; end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1); n++;
      chk("hold_counter", 32'(counter), 32'd5);
    end
    finish_run(n, n);
    chk("hold_latency", 32'(n), 32'(NS * L + 4));
    step(0, 0, 0);
    // abort mid-run, then abort together with start
    step(1, 0, 0);
    run_to(3 * L + 2);
    step(0, 1, 0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_stage", 32'(stage_num), 32'd7);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(1, 1, 0);
    chk("abort_start_idle", 32'(ready), 32'd1);
    // asynchronous reset during stage 1 drain
    step(1, 0, 0);
    run_to(L + B);
    #1 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("async_reset_stage", 32'(stage_num), 32'd7);
    #1 rst_n = 1;
    step(1, 0, 0);
    chk("restart_stage", 32'(stage_num), 32'd0);
    chk("restart_counter", 32'(counter), 32'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) == 0, $urandom_range(63) == 0, $urandom_range(7) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
